demux_1x4_stream: RTL and testbench
===================================

Name: demux_1x4_stream

Overview:
- Sequential 1-to-4 stream demultiplexer, the distribution-side counterpart of the 4:1 selector muxes in the datapath.
- Routes each accepted input word to one of four output channels chosen by a 2-bit select sampled with the word.
- Each channel has its own 2-entry buffer and valid/ready handshake, so a stalled channel does not block traffic addressed to other channels.

Parameters:
- DW, 8, data width in bits of the input word and of each output channel.

Ports:
- clk  input  1  single clock; all state updates on rising edge.
- rst_n  input  1  asynchronous active-low reset.
- in_data  input  DW  input word.
- in_sel  input  2  destination channel for in_data (0..3); s1 is the MSB and s0 the LSB.
- in_valid  input  1  input word and select are valid.
- in_ready  output  1  the block accepts the word this cycle.
- out_data0..out_data3  output  DW each  head-of-buffer word for channel k.
- out_valid0..out_valid3  output  1 each  channel k buffer is non-empty.
- out_ready0..out_ready3  input  1 each  the consumer of channel k takes the head word this cycle.
- occ0..occ3  output  2 each  occupancy of channel k (0, 1 or 2).

Behaviour:
- Reset (async assert, sync-to-clk deassert handled externally):
  - All buffers empty; occ0..3 = 0; out_valid0..3 = 0; out_data0..3 = 0.
  - Storage entries cleared to 0.
- Input handshake:
  - in_ready = NOT full[in_sel], where full = (occ == 2). This path is combinational from in_sel.
  - in_ready is independent of in_valid.
  - An input transfer occurs when in_valid && in_ready at the rising edge.
- Output handshake:
  - A channel-k transfer occurs when out_valid_k && out_ready_k at the rising edge.
  - out_ready_k while out_valid_k = 0 has no effect.
- Latency:
  - A word accepted at edge N into an empty channel appears on out_data_k with out_valid_k = 1 after edge N. This is 1-cycle latency, with no combinational in→out path.
- Per-channel state machine (state = occ):
  - EMPTY: push → ONE.
  - ONE: push && !pop → TWO; pop && !push → EMPTY; push && pop → ONE, and the new word becomes head.
  - TWO: pop → ONE, and the second entry becomes head. Push is impossible because in_ready = 0 for this channel.
  - A simultaneous pop does NOT enable a push when full. This rule is deliberate; it keeps in_ready free of an out_ready path.
- Ordering and independence:
  - FIFO order within a channel.
  - There is no ordering guarantee across channels.
  - Only the addressed channel changes on a push. Pops on all four channels may occur in the same cycle as a push to any channel.
- Data:
  - out_data_k is stable while out_valid_k = 1 and out_ready_k = 0.
  - in_data is stored unmodified, full DW bits.
- Stalled input (in_valid = 1, in_ready = 0):
  - Nothing is stored.
  - The source may hold or change in_sel. in_ready re-evaluates combinationally against the new channel.
- Reset mid-operation: all buffered words are discarded immediately on rst_n low; outputs go to reset values asynchronously.

Test Plan:
- Reset then idle → occ0..3 = 0, out_valid0..3 = 0, in_ready = 1 for every in_sel.
- Send 0xA1 sel=2, out_ready2 = 1 → out_valid2 = 1 with 0xA1 one cycle later; channel 2 drains next edge; other channels stay invalid.
- Push 0x11, 0x22, 0x33 to sel=1 with out_ready1 = 0:
  - After two pushes occ1 = 2 and in_ready = 0 for sel=1.
  - Switch in_sel to 3 → in_ready = 1 and 0x33 lands in channel 3.
  - Release out_ready1 → 0x11 then 0x22 in order.
- Channel 0 at occ = 2 with pop and push in the same cycle → push refused (in_ready = 0), occ0 = 1 after the edge, head = second word.
- occ = 1 with push && pop → occ stays 1, head = new word, no data loss; run a random 1000-word stream across all sels with random ready → scoreboard per-channel order.
- Assert rst_n low mid-stream with all channels at occ = 2 → all out_valid drop immediately; after release all occ = 0 and the first new word has 1-cycle latency.

Source files
------------

// File: rtl/demux_1x4_stream_if.sv
// Stream bus for the 1-to-4 demultiplexer: one select-addressed input side and
// four independent valid/ready output channels with occupancy.
interface demux_1x4_stream_if #(parameter int DW = 8);
    logic [DW-1:0] in_data;
    logic [1:0]    in_sel;
    logic          in_valid;
    logic          in_ready;
    logic [DW-1:0] out_data0, out_data1, out_data2, out_data3;
    logic          out_valid0, out_valid1, out_valid2, out_valid3;
    logic          out_ready0, out_ready1, out_ready2, out_ready3;
    logic [1:0]    occ0, occ1, occ2, occ3;

    // master drives words in and consumes channels; slave is the demux
    modport master (
        output in_data, in_sel, in_valid,
        output out_ready0, out_ready1, out_ready2, out_ready3,
        input  in_ready,
        input  out_data0, out_data1, out_data2, out_data3,
        input  out_valid0, out_valid1, out_valid2, out_valid3,
        input  occ0, occ1, occ2, occ3
    );
    modport slave (
        input  in_data, in_sel, in_valid,
        input  out_ready0, out_ready1, out_ready2, out_ready3,
        output in_ready,
        output out_data0, out_data1, out_data2, out_data3,
        output out_valid0, out_valid1, out_valid2, out_valid3,
        output occ0, occ1, occ2, occ3
    );
endinterface

// File: rtl/demux_1x4_stream.sv
// 1-to-4 stream demultiplexer: each accepted word is steered by in_sel into one
// of four 2-entry channel buffers, each with its own valid/ready handshake.
module demux_1x4_chan #(parameter int DW = 8) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          push,
    input  logic          ordy,
    input  logic [DW-1:0] din,
    output logic [DW-1:0] dout,
    output logic          vld,
    output logic          full,
    output logic [1:0]    occ
);
    typedef enum logic [1:0] {EMPTY = 2'd0, ONE = 2'd1, TWO = 2'd2} st_t;

    st_t           st, st_nx;
    logic [DW-1:0] head, tail;
    logic          ld_head_in, ld_head_tail, ld_tail, pop;

    assign vld  = (st != EMPTY);
    assign full = (st == TWO);
    assign occ  = st;
    assign dout = head;
    assign pop  = vld & ordy;

    always_comb begin
        st_nx        = st;
        ld_head_in   = 1'b0;
        ld_head_tail = 1'b0;
        ld_tail      = 1'b0;
        case (st)
            EMPTY: if (push) begin
                st_nx      = ONE;
                ld_head_in = 1'b1;
            end
            ONE: case ({push, pop})
                2'b10: begin st_nx = TWO; ld_tail = 1'b1; end
                2'b01: st_nx = EMPTY;
                // head leaves and the new word replaces it in one cycle
                2'b11: ld_head_in = 1'b1;
                default: ;
            endcase
            // push cannot occur here: in_ready is low for a full channel
            TWO: if (pop) begin
                st_nx        = ONE;
                ld_head_tail = 1'b1;
            end
            default: st_nx = EMPTY;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            st   <= EMPTY;
            head <= '0;
            tail <= '0;
        end else begin
            st <= st_nx;
            if (ld_head_in)        head <= din;
            else if (ld_head_tail) head <= tail;
            if (ld_tail)           tail <= din;
        end
    end
endmodule

module demux_1x4_stream #(parameter int DW = 8) (
    input  logic                 clk,
    input  logic                 rst_n,
    demux_1x4_stream_if.slave    bus
);
    localparam int NUM_LANES = 4;

    logic [NUM_LANES-1:0][DW-1:0] dout;
    logic [NUM_LANES-1:0]         vld, full, ordy, push;
    logic [NUM_LANES-1:0][1:0]    occ;

    assign ordy = {bus.out_ready3, bus.out_ready2, bus.out_ready1, bus.out_ready0};

    // ready depends only on the addressed channel's fill level, never on out_ready
    assign bus.in_ready = ~full[bus.in_sel];

    for (genvar k = 0; k < NUM_LANES; k++) begin : g_chan
        assign push[k] = bus.in_valid & bus.in_ready & (bus.in_sel == 2'(k));
        demux_1x4_chan #(.DW(DW)) u_chan (
            .clk   (clk),
            .rst_n (rst_n),
            .push  (push[k]),
            .ordy  (ordy[k]),
            .din   (bus.in_data),
            .dout  (dout[k]),
            .vld   (vld[k]),
            .full  (full[k]),
            .occ   (occ[k])
        );
    end

    assign bus.out_data0  = dout[0];
    assign bus.out_data1  = dout[1];
    assign bus.out_data2  = dout[2];
    assign bus.out_data3  = dout[3];
    assign bus.out_valid0 = vld[0];
    assign bus.out_valid1 = vld[1];
    assign bus.out_valid2 = vld[2];
    assign bus.out_valid3 = vld[3];
    assign bus.occ0       = occ[0];
    assign bus.occ1       = occ[1];
    assign bus.occ2       = occ[2];
    assign bus.occ3       = occ[3];
endmodule

// File: tb/tb_demux_1x4_stream.sv
// Bench for demux_1x4_stream: directed steps plus a random stream, with a
// per-channel scoreboard that also models occupancy and in_ready.
module tb_demux_1x4_stream;
    logic clk, rst_n;
    int   checks = 0, failures = 0, accepted = 0;

    demux_1x4_stream_if #(.DW(8)) bus ();
    demux_1x4_stream #(.DW(8)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

    logic [3:0] ordy;
    assign bus.out_ready0 = ordy[0];
    assign bus.out_ready1 = ordy[1];
    assign bus.out_ready2 = ordy[2];
    assign bus.out_ready3 = ordy[3];

    wire [3:0] ov = {bus.out_valid3, bus.out_valid2, bus.out_valid1, bus.out_valid0};
    wire [7:0] od [4];
    wire [1:0] oc [4];
    assign od[0] = bus.out_data0; assign od[1] = bus.out_data1;
    assign od[2] = bus.out_data2; assign od[3] = bus.out_data3;
    assign oc[0] = bus.occ0; assign oc[1] = bus.occ1;
    assign oc[2] = bus.occ2; assign oc[3] = bus.occ3;

    logic [7:0] sb [4][$];

    initial begin
        clk = 0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Sampled mid-cycle: checks current state against the model, then applies
    // the transfers that the next rising edge will perform.
    always @(negedge clk) begin
        if (rst_n) begin
            logic mrdy;
            mrdy = (sb[bus.in_sel].size() < 2);
            chk("mon_in_ready", 32'(bus.in_ready), 32'(mrdy));
            for (int k = 0; k < 4; k++) begin
                chk($sformatf("mon_occ%0d", k), 32'(oc[k]), 32'(sb[k].size()));
                chk($sformatf("mon_valid%0d", k), 32'(ov[k]), 32'(sb[k].size() != 0));
                if (ov[k] && ordy[k]) begin
                    if (sb[k].size() == 0) chk($sformatf("mon_unexpected%0d", k), 32'(od[k]), 32'hFFFF_FFFF);
                    else chk($sformatf("mon_data%0d", k), 32'(od[k]), 32'(sb[k].pop_front()));
                end
            end
            if (bus.in_valid && mrdy) begin
                sb[bus.in_sel].push_back(bus.in_data);
                accepted++;
            end
        end
    end

    task automatic step();
        @(posedge clk); #1;
    endtask

    task automatic send(input logic [1:0] s, input logic [7:0] d);
        bus.in_sel = s; bus.in_data = d; bus.in_valid = 1'b1;
        step();
        bus.in_valid = 1'b0;
    endtask

    initial begin
        rst_n = 0; bus.in_valid = 0; bus.in_sel = 0; bus.in_data = 0; ordy = 0;
        repeat (2) @(posedge clk); #1;
        for (int k = 0; k < 4; k++) begin
            chk($sformatf("rst_occ%0d", k), 32'(oc[k]), 0);
            chk($sformatf("rst_data%0d", k), 32'(od[k]), 0);
        end
        chk("rst_valid", 32'(ov), 0);
        rst_n = 1;
        for (int s = 0; s < 4; s++) begin
            bus.in_sel = 2'(s); #1;
            chk($sformatf("idle_ready_sel%0d", s), 32'(bus.in_ready), 1);
        end
        step();

        // single word, 1-cycle latency, drains on next edge
        ordy = 4'b0100;
        send(2'd2, 8'hA1);
        chk("a1_valid", 32'(ov), 32'b0100);
        chk("a1_data", 32'(od[2]), 32'hA1);
        step();
        chk("a1_drained", 32'(ov), 0);

        // fill channel 1, redirect the stalled word to channel 3
        ordy = 4'b0000;
        send(2'd1, 8'h11);
        send(2'd1, 8'h22);
        chk("c1_occ_full", 32'(oc[1]), 2);
        bus.in_sel = 2'd1; bus.in_data = 8'h33; bus.in_valid = 1'b1; #1;
        chk("c1_full_ready", 32'(bus.in_ready), 0);
        bus.in_sel = 2'd3; #1;
        chk("c3_ready", 32'(bus.in_ready), 1);
        step();
        bus.in_valid = 1'b0;
        chk("c3_data", 32'(od[3]), 32'h33);
        chk("c1_unchanged", 32'(oc[1]), 2);
        ordy = 4'b1010;
        chk("c1_head0", 32'(od[1]), 32'h11);
        step();
        chk("c1_head1", 32'(od[1]), 32'h22);
        step();
        chk("c1_c3_empty", 32'(ov), 0);

        // full channel: simultaneous pop does not open the input
        ordy = 4'b0000;
        send(2'd0, 8'h40);
        send(2'd0, 8'h41);
        ordy = 4'b0001;
        bus.in_sel = 2'd0; bus.in_data = 8'h42; bus.in_valid = 1'b1; #1;
        chk("c0_full_pop_ready", 32'(bus.in_ready), 0);
        step();
        bus.in_valid = 1'b0;
        chk("c0_occ_after", 32'(oc[0]), 1);
        chk("c0_head_after", 32'(od[0]), 32'h41);
        step();

        // occ=1 with push and pop together
        ordy = 4'b0000;
        send(2'd2, 8'h50);
        ordy = 4'b0100;
        send(2'd2, 8'h51);
        chk("c2_pp_occ", 32'(oc[2]), 1);
        chk("c2_pp_head", 32'(od[2]), 32'h51);
        step();
        chk("c2_pp_empty", 32'(ov[2]), 0);

        // random stream
        accepted = 0;
        for (int c = 0; c < 20000 && accepted < 1000; c++) begin
            bus.in_valid = 1'($urandom_range(0, 1));
            bus.in_sel   = 2'($urandom_range(0, 3));
            bus.in_data  = 8'($urandom);
            ordy         = 4'($urandom);
            step();
        end
        chk("rand_accepted", 32'(accepted >= 1000), 1);
        bus.in_valid = 1'b0; ordy = 4'hF;
        repeat (4) step();
        for (int k = 0; k < 4; k++) chk($sformatf("rand_drained%0d", k), 32'(sb[k].size()), 0);

        // reset with every channel full
        ordy = 4'b0000;
        for (int k = 0; k < 8; k++) send(2'(k % 4), 8'(8'h80 + k));
        for (int k = 0; k < 4; k++) chk($sformatf("pre_rst_occ%0d", k), 32'(oc[k]), 2);
        rst_n = 1'b0; #1;
        chk("mid_rst_valid", 32'(ov), 0);
        for (int k = 0; k < 4; k++) sb[k].delete();
        step();
        rst_n = 1'b1;
        for (int k = 0; k < 4; k++) chk($sformatf("post_rst_occ%0d", k), 32'(oc[k]), 0);
        ordy = 4'b0010;
        send(2'd1, 8'h77);
        chk("post_rst_valid", 32'(ov), 32'b0010);
        chk("post_rst_data", 32'(od[1]), 32'h77);
        step();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
